work_uart_tx: RTL and testbench

Serialises one mining job (midstate, work data, nonce range) into a UART 8N1 byte stream. The byte layout is exactly the one the UART comm block's receiver parses into `midstate`, `work_data`, `nonce_min` and `nonce_max`. It is the transmit end of the work-loading protocol. It is used for on-board self-test (looped back into the miner's RX pin) and by the host-emulation bitstream that drives a second board.

---
 rtl/miner_pkg.sv | 20 ++
 rtl/uart_tx_byte.sv | 90 +++++++++
 rtl/work_uart_tx.sv | 97 +++++++++
 tb/tb_work_uart_tx.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/miner_pkg.sv
// Shared definitions for the work-loading protocol: packet geometry, field
// byte offsets and the UART transmit FSM state encoding.
package miner_pkg;

  localparam int WORK_BYTES = 52;
  localparam int WORK_BITS  = 416;

  localparam int OFS_MIDSTATE  = 0;
  localparam int OFS_WORK_DATA = 32;
  localparam int OFS_NONCE_MIN = 44;
  localparam int OFS_NONCE_MAX = 48;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser. A new byte can be accepted in the last cycle of a stop
// bit, so consecutive bytes leave the line with no idle gap between them.
module uart_tx_byte
  import miner_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx_serial,
  output logic [1:0] dbg_state
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] LAST_TICK = TW'(CLKS_PER_BIT - 1);

  uart_state_t   r_state, w_state_n;
  logic [TW-1:0] r_timer, w_timer_n;
  logic [2:0]    r_bit, w_bit_n;
  logic [7:0]    r_data, w_data_n;
  logic          w_bit_end;

  assign w_bit_end = (r_timer == LAST_TICK);
  assign dbg_state = r_state;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_timer <= '0;
      r_bit   <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_n;
      r_timer <= w_timer_n;
      r_bit   <= w_bit_n;
      r_data  <= w_data_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_timer_n = r_timer;
    w_bit_n   = r_bit;
    w_data_n  = r_data;
    ready     = 1'b0;
    tx_serial = 1'b1;
    case (r_state)
      IDLE: begin
        ready = 1'b1;
        if (valid) begin
          w_state_n = START;
          w_timer_n = '0;
          w_bit_n   = '0;
          w_data_n  = data;
        end
      end
      START: begin
        tx_serial = 1'b0;
        w_timer_n = w_bit_end ? '0 : r_timer + 1'b1;
        if (w_bit_end) w_state_n = DATA;
      end
      DATA: begin
        tx_serial = r_data[r_bit];
        w_timer_n = w_bit_end ? '0 : r_timer + 1'b1;
        if (w_bit_end) begin
          if (r_bit == 3'd7) w_state_n = STOP;
          else               w_bit_n   = r_bit + 1'b1;
        end
      end
      STOP: begin
        ready     = w_bit_end;
        w_timer_n = w_bit_end ? '0 : r_timer + 1'b1;
        if (w_bit_end) begin
          if (valid) begin
            w_state_n = START;
            w_bit_n   = '0;
            w_data_n  = data;
          end else begin
            w_state_n = IDLE;
          end
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

endmodule

// File: rtl/work_uart_tx.sv
// Sends one mining job as a 52-byte UART packet (MSB byte first per field).
// Define WORK_TX_CHECKSUM_EN to append a 53rd XOR checksum byte.
module work_uart_tx
  import miner_pkg::*;
#(
  parameter int baud_rate    = 9600,
  parameter int sys_clk_freq = 12000000
) (
  input  logic         comm_clk,
  input  logic         reset,
  input  logic         start,
  input  logic [255:0] midstate,
  input  logic [95:0]  work_data,
  input  logic [31:0]  nonce_min,
  input  logic [31:0]  nonce_max,
  output logic         busy,
  output logic         done,
  output logic         tx_serial,
  output logic [1:0]   dbg_state
);

  localparam int CLKS_PER_BIT = sys_clk_freq / baud_rate;
`ifdef WORK_TX_CHECKSUM_EN
  localparam logic [5:0] TOTAL_BYTES = 6'(WORK_BYTES + 1);
`else
  localparam logic [5:0] TOTAL_BYTES = 6'(WORK_BYTES);
`endif

  logic [WORK_BITS-1:0] w_packet, r_shift;
  logic [5:0]           r_byte_cnt;
  logic                 r_busy, r_done;
  logic                 w_launch, w_more, w_finish;
  logic                 w_tx_valid, w_tx_ready;
  logic [7:0]           w_tx_data, w_next_byte;

  // Handshake to the serialiser: a byte moves when valid and ready are both
  // high on a clock edge; valid and data stay stable until that edge.
  assign w_packet   = {midstate, work_data, nonce_min, nonce_max};
  assign w_launch   = start & ~r_busy & ~r_done;
  assign w_more     = r_busy & (r_byte_cnt < TOTAL_BYTES);
  assign w_finish   = r_busy & (r_byte_cnt == TOTAL_BYTES) & w_tx_ready;
  assign w_tx_valid = w_launch | w_more;
  assign w_tx_data  = w_launch ? w_packet[WORK_BITS-1 -: 8] : w_next_byte;
  assign busy       = r_busy;
  assign done       = r_done;

`ifdef WORK_TX_CHECKSUM_EN
  logic [7:0] r_csum;

  assign w_next_byte = (r_byte_cnt == 6'(WORK_BYTES)) ? r_csum : r_shift[WORK_BITS-1 -: 8];

  // The payload is drained by then, so the checksum byte's own hand-off XORs in zero.
  always_ff @(posedge comm_clk) begin
    if (reset)                      r_csum <= '0;
    else if (w_launch)              r_csum <= w_packet[WORK_BITS-1 -: 8];
    else if (w_more && w_tx_ready)  r_csum <= r_csum ^ r_shift[WORK_BITS-1 -: 8];
  end
`else
  assign w_next_byte = r_shift[WORK_BITS-1 -: 8];
`endif

  always_ff @(posedge comm_clk) begin
    if (reset) begin
      r_shift    <= '0;
      r_byte_cnt <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_launch) begin
        r_shift    <= {w_packet[WORK_BITS-9:0], 8'h00};
        r_byte_cnt <= 6'd1;
        r_busy     <= 1'b1;
      end else if (w_more && w_tx_ready) begin
        r_shift    <= {r_shift[WORK_BITS-9:0], 8'h00};
        r_byte_cnt <= r_byte_cnt + 6'd1;
      end else if (w_finish) begin
        r_busy     <= 1'b0;
        r_done     <= 1'b1;
        r_byte_cnt <= '0;
      end
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx_byte (
    .clk      (comm_clk),
    .reset    (reset),
    .data     (w_tx_data),
    .valid    (w_tx_valid),
    .ready    (w_tx_ready),
    .tx_serial(tx_serial),
    .dbg_state(dbg_state)
  );

endmodule

// File: tb/tb_work_uart_tx.sv
// Bench for work_uart_tx: random and directed jobs checked by a UART-decoding
// monitor and a done-timing monitor against a packet-level reference model.
module tb_work_uart_tx;

  localparam int SYS     = 12000000;
  localparam int BAUD    = 1500000;
  localparam int CPB     = SYS / BAUD;
`ifdef WORK_TX_CHECKSUM_EN
  localparam int TOTAL   = 53;
`else
  localparam int TOTAL   = 52;
`endif
  localparam int PKT_CYC = TOTAL * 10 * CPB;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [255:0] midstate = '0;
  logic [95:0]  work_data = '0;
  logic [31:0]  nonce_min = '0;
  logic [31:0]  nonce_max = '0;
  logic         busy, done, tx;
  logic [1:0]   dbg_state;

  work_uart_tx #(
    .baud_rate   (BAUD),
    .sys_clk_freq(SYS)
  ) dut (
    .comm_clk (clk),
    .reset    (rst),
    .start    (start),
    .midstate (midstate),
    .work_data(work_data),
    .nonce_min(nonce_min),
    .nonce_max(nonce_max),
    .busy     (busy),
    .done     (done),
    .tx_serial(tx),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int         checks = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  int         done_q[$];
  int         launch_q[$];
  bit         m_have = 1'b0;
  int         m_done = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endfunction

  function automatic void fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: got unexpected event expected none at cycle %0d", name, cyc);
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom();
    return v;
  endfunction

  // Reference model: the packet is every field's bytes, most significant first,
  // in field order; the line is busy for TOTAL*10 bit periods after launch.
  function automatic void model_job(input int n, input logic [255:0] m, input logic [95:0] w,
                                    input logic [31:0] a, input logic [31:0] b);
    logic [7:0] cs;
    cs = 8'h00;
    for (int i = 0; i < 32; i++) begin exp_q.push_back(m[255-8*i -: 8]); cs ^= m[255-8*i -: 8]; end
    for (int i = 0; i < 12; i++) begin exp_q.push_back(w[95-8*i -: 8]);  cs ^= w[95-8*i -: 8];  end
    for (int i = 0; i < 4; i++)  begin exp_q.push_back(a[31-8*i -: 8]);  cs ^= a[31-8*i -: 8];  end
    for (int i = 0; i < 4; i++)  begin exp_q.push_back(b[31-8*i -: 8]);  cs ^= b[31-8*i -: 8];  end
`ifdef WORK_TX_CHECKSUM_EN
    exp_q.push_back(cs);
`endif
    launch_q.push_back(n + 1);
    done_q.push_back(n + 1 + PKT_CYC);
    m_have = 1'b1;
    m_done = n + 1 + PKT_CYC;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic s, input logic [255:0] m, input logic [95:0] w,
                       input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    start = s; midstate = m; work_data = w; nonce_min = a; nonce_max = b;
    if (s && (!m_have || cyc > m_done)) model_job(cyc, m, w, a, b);
  endtask

  task automatic idle_cycle();
    drive(1'b0, midstate, work_data, nonce_min, nonce_max);
  endtask

  task automatic noise_cycle(input int start_pct);
    drive(($urandom_range(99) < start_pct) && (cyc + 1 <= m_done), rand256(), rand256()[95:0],
          $urandom(), $urandom());
  endtask

  task automatic do_reset(input logic s);
    @(posedge clk); #1;
    rst = 1'b1; start = s;
    exp_q.delete(); done_q.delete(); launch_q.delete();
    m_have = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < PKT_CYC + 200 && (exp_q.size() != 0 || done_q.size() != 0); i++) idle_cycle();
    check("drain_pending", 64'(exp_q.size() + done_q.size()), 64'd0);
  endtask

  task automatic wait_free(input int gap);
    while (cyc + 1 < m_done + gap) noise_cycle(3);
  endtask

  // ---------------- UART monitor ----------------
  bit         mon_act = 1'b0;
  int         mon_cnt = 0;
  int         mon_k;
  logic [7:0] mon_byte;

  always @(negedge clk) begin
    if (rst) begin
      mon_act = 1'b0;
    end else if (!mon_act) begin
      if (tx === 1'b0) begin mon_act = 1'b1; mon_cnt = 0; end
    end else begin
      mon_cnt++;
      if (mon_cnt == CPB / 2) begin
        check("start_bit", 64'(tx), 64'd0);
      end else if (mon_cnt > CPB / 2 && ((mon_cnt - CPB / 2) % CPB) == 0) begin
        mon_k = (mon_cnt - CPB / 2) / CPB;
        if (mon_k <= 8) begin
          mon_byte[mon_k-1] = tx;
        end else begin
          check("stop_bit", 64'(tx), 64'd1);
          if (exp_q.size() == 0) fail_now("unexpected_byte");
          else check("byte", 64'(mon_byte), 64'(exp_q.pop_front()));
          mon_act = 1'b0;
        end
      end
    end
  end

  // ---------------- launch / done monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (launch_q.size() != 0 && launch_q[0] == cyc) begin
        void'(launch_q.pop_front());
        check("launch_busy", 64'(busy), 64'd1);
        check("launch_tx", 64'(tx), 64'd0);
      end
      if (done === 1'b1) begin
        check("done_busy", 64'(busy), 64'd0);
        if (done_q.size() == 0) fail_now("unexpected_done");
        else check("done_cycle", 64'(cyc), 64'(done_q.pop_front()));
      end
    end
  end

  // ---------------- stimulus ----------------
  int t_end;
  int t_rst;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_tx", 64'(tx), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    // Long idle: line high, never busy.
    for (int i = 0; i < 5000; i++) begin
      idle_cycle();
      @(negedge clk);
      check("idle_tx", 64'(tx), 64'd1);
      check("idle_busy", 64'(busy), 64'd0);
    end

    // Directed packet.
    drive(1'b1, 256'h1, 96'hAABBCCDDEEFF112233445566, 32'h0, 32'hFFFFFFFF);
    idle_cycle();
    drain();

    // Uniform 5A fields, then the same with the last nonce byte bumped.
    drive(1'b1, {8{32'h5A5A5A5A}}, {3{32'h5A5A5A5A}}, 32'h5A5A5A5A, 32'h5A5A5A5A);
    idle_cycle();
    drain();
    drive(1'b1, {8{32'h5A5A5A5A}}, {3{32'h5A5A5A5A}}, 32'h5A5A5A5A, 32'h5A5A5A5B);
    idle_cycle();
    drain();

    // Start held every cycle, including the done cycle, with changing inputs.
    drive(1'b1, rand256(), rand256()[95:0], $urandom(), $urandom());
    t_end = m_done;
    while (cyc + 1 <= t_end) drive(1'b1, rand256(), rand256()[95:0], $urandom(), $urandom());
    idle_cycle();
    for (int i = 0; i < 40; i++) begin
      idle_cycle();
      @(negedge clk);
      check("no_restart_busy", 64'(busy), 64'd0);
    end
    drain();

    // Random jobs launched 1..3 cycles after the previous done, with ignored starts in between.
    for (int j = 0; j < 6; j++) begin
      wait_free($urandom_range(1, 3));
      drive(1'b1, rand256(), rand256()[95:0], $urandom(), $urandom());
    end
    wait_free(2);
    drain();

    // Reset inside byte 20's data bits, with start asserted alongside.
    drive(1'b1, rand256(), rand256()[95:0], $urandom(), $urandom());
    t_rst = cyc + 1 + 20 * 10 * CPB + 4 * CPB;
    while (cyc + 1 < t_rst) idle_cycle();
    do_reset(1'b1);
    @(negedge clk);
    check("mid_rst_tx", 64'(tx), 64'd1);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    for (int i = 0; i < 20; i++) begin
      idle_cycle();
      @(negedge clk);
      check("post_rst_busy", 64'(busy), 64'd0);
    end
    drive(1'b1, rand256(), rand256()[95:0], $urandom(), $urandom());
    idle_cycle();
    drain();

    for (int i = 0; i < 2 * 10 * CPB; i++) idle_cycle();
    check("final_bytes_left", 64'(exp_q.size()), 64'd0);
    check("final_done_left", 64'(done_q.size()), 64'd0);
    check("final_monitor_idle", 64'(mon_act), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
